// File: rtl/ram_lsu_adapter_pkg.sv
// Shared definitions for the RAM load/store adapter: access-size and FSM
// state encodings, RAM strobe/data constants and the alignment check.
package ram_lsu_adapter_pkg;

    typedef enum logic [1:0] {
        SizeByte    = 2'b00,
        SizeHalf    = 2'b01,
        SizeWord    = 2'b10,
        SizeIllegal = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRd   = 2'b01,
        StWr   = 2'b10,
        StDone = 2'b11
    } state_e;

    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    // Flags illegal sizes and accesses not aligned to their natural size.
    function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SizeByte: bad = 1'b0;
            SizeHalf: bad = off[0];
            SizeWord: bad = (off != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ram_lsu_adapter_lane.sv
// Byte-lane datapath: extracts and sign/zero-extends a load lane from a RAM
// word, and merges store data into an existing word for read-modify-write.
module lsu_byte_lane
    import ram_lsu_adapter_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign;

    // Select the addressed byte and halfword lanes of the word.
    always_comb begin
        w_byte = 8'h00;
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_off[1]) begin
            w_half = i_word[31:16];
        end else begin
            w_half = i_word[15:0];
        end
    end

    // Extend the selected lane to 32 bits; unsigned loads zero-fill.
    always_comb begin
        o_load = i_word;
        w_sign = 1'b0;
        case (i_size)
            SizeByte: begin
                w_sign = ~i_unsigned & w_byte[7];
                o_load = {{24{w_sign}}, w_byte};
            end
            SizeHalf: begin
                w_sign = ~i_unsigned & w_half[15];
                o_load = {{16{w_sign}}, w_half};
            end
            default: begin
                w_sign = 1'b0;
                o_load = i_word;
            end
        endcase
    end

    // Replace only the target lane of the old word with store data.
    always_comb begin
        o_merge = i_word;
        case (i_size)
            SizeByte: begin
                case (i_off)
                    2'd0:    o_merge[7:0]   = i_wdata[7:0];
                    2'd1:    o_merge[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge[23:16] = i_wdata[7:0];
                    2'd3:    o_merge[31:24] = i_wdata[7:0];
                    default: o_merge = i_word;
                endcase
            end
            SizeHalf: begin
                if (i_off[1]) begin
                    o_merge[31:16] = i_wdata[15:0];
                end else begin
                    o_merge[15:0] = i_wdata[15:0];
                end
            end
            default: o_merge = i_wdata;
        endcase
    end

endmodule

// File: rtl/ram_lsu_adapter.sv
// Adapter between the core memory stage and a word-only data RAM. Converts
// byte/half/word loads and stores into word accesses; sub-word stores are
// read-modify-write. Optional macro RAM_BOUNDS_CHECK_EN makes word indices
// at or beyond DEPTH an access error.
module ram_lsu_adapter
    import ram_lsu_adapter_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_we_o,
    output logic [31:0] mem_waddr_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] mem_raddr_o,
    input  logic [31:0] mem_rdata_i
);

`ifdef RAM_BOUNDS_CHECK_EN
    localparam logic BoundsCheck = 1'b1;
`else
    localparam logic BoundsCheck = 1'b0;
`endif

    state_e      r_state;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_wdata;

    logic        w_oob;
    logic        w_err;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    // Indices past DEPTH, or past what AW bits can decode, are out of range.
    assign w_oob = BoundsCheck &
                   (({2'b00, addr_i[31:2]} >= 32'(DEPTH)) | (|(addr_i[31:2] >> AW)));
    assign w_err = access_illegal(size_i, addr_i[1:0]) | w_oob;

    lsu_byte_lane u_lane (
        .i_word     (mem_rdata_i),
        .i_off      (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    assign busy_o      = (r_state != StIdle);
    assign done_o      = (r_state == StDone);
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;
    assign mem_we_o    = (r_state == StWr) ? WriteEnable : ~WriteEnable;
    assign mem_waddr_o = {r_addr[31:2], 2'b00};
    assign mem_raddr_o = {r_addr[31:2], 2'b00};
    assign mem_wdata_o = r_mem_wdata;

    // Access sequencer: accept, optional RAM read, optional RAM write, done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_we        <= 1'b0;
            r_addr      <= ZeroWord;
            r_wdata     <= ZeroWord;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= ZeroWord;
            r_mem_wdata <= ZeroWord;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_i) begin
                        r_we       <= we_i;
                        r_addr     <= addr_i;
                        r_wdata    <= wdata_i;
                        r_size     <= size_i;
                        r_unsigned <= unsigned_i;
                        r_err      <= w_err;
                        if (w_err) begin
                            r_rdata <= ZeroWord;
                            r_state <= StDone;
                        end else if (we_i && (size_i == SizeWord)) begin
                            r_mem_wdata <= wdata_i;
                            r_state     <= StWr;
                        end else begin
                            r_state <= StRd;
                        end
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StRd: begin
                    if (r_we) begin
                        r_mem_wdata <= w_merge;
                        r_state     <= StWr;
                    end else begin
                        r_rdata <= w_load;
                        r_state <= StDone;
                    end
                end
                StWr: begin
                    r_state <= StDone;
                end
                StDone: begin
                    r_err   <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_lsu_adapter.sv
// Directed self-checking bench for ram_lsu_adapter with a behavioural
// 256-word RAM (index wraps on address bits [9:2]).
module tb_ram_lsu_adapter;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        mem_we_o;
    logic [31:0] mem_waddr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_raddr_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] mem [0:255];

    int          checks;
    int          failures;
    int          lat;
    int          we_cnt;
    logic [31:0] wr_data;
    logic [31:0] wr_addr;
    logic        res_err;
    logic [31:0] res_rdata;
    logic        got_done;

    ram_lsu_adapter #(.DEPTH(256), .AW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .size_i      (size_i),
        .unsigned_i  (unsigned_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .mem_we_o    (mem_we_o),
        .mem_waddr_o (mem_waddr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_raddr_o (mem_raddr_o),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata_i = mem[mem_raddr_o[9:2]];

    // Behavioural RAM write port.
    always @(posedge clk) begin
        if (mem_we_o) mem[mem_waddr_o[9:2]] <= mem_wdata_o;
    end

    // Issue one request and watch it to completion (bounded wait).
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [1:0] sz, input logic uns);
        @(negedge clk);
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; size_i = sz; unsigned_i = uns;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        lat = 0; we_cnt = 0; wr_data = 32'h0; wr_addr = 32'h0;
        res_err = 1'b0; res_rdata = 32'h0; got_done = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_we_o) begin
                we_cnt++; wr_data = mem_wdata_o; wr_addr = mem_waddr_o;
            end
            if (done_o) begin
                lat = c; res_err = err_o; res_rdata = rdata_o; got_done = 1'b1;
                break;
            end
        end
        checks++;
        if (got_done !== 1'b1) begin
            failures++; $display("FAIL timeout addr=%h got_done=%b exp=1", addr, got_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
        size_i = 2'b00; unsigned_i = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, err_o, mem_we_o} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {busy_o, done_o, err_o, mem_we_o});
        end
        checks++;
        if ({rdata_o, mem_waddr_o, mem_wdata_o, mem_raddr_o} !== 128'h0) begin
            failures++; $display("FAIL reset_data got=%h %h %h %h exp=0", rdata_o, mem_waddr_o, mem_wdata_o, mem_raddr_o);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_word();
        do_access(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0);
        checks++; if (lat !== 2) begin failures++; $display("FAIL sw_lat got=%0d exp=2", lat); end
        checks++; if (we_cnt !== 1) begin failures++; $display("FAIL sw_we_cnt got=%0d exp=1", we_cnt); end
        checks++; if (wr_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", wr_data); end
        checks++; if (wr_addr !== 32'h10) begin failures++; $display("FAIL sw_waddr got=%h exp=00000010", wr_addr); end
        checks++; if (res_err !== 1'b0) begin failures++; $display("FAIL sw_err got=%b exp=0", res_err); end
        do_access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        checks++; if (lat !== 2) begin failures++; $display("FAIL lw_lat got=%0d exp=2", lat); end
        checks++; if (we_cnt !== 0) begin failures++; $display("FAIL lw_we_cnt got=%0d exp=0", we_cnt); end
        checks++; if (res_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", res_rdata); end
        checks++; if (res_err !== 1'b0) begin failures++; $display("FAIL lw_err got=%b exp=0", res_err); end
    endtask

    task automatic test_subword_store();
        mem[8] = 32'h1122_3344;
        do_access(1'b1, 32'h21, 32'hFFFF_FFAA, 2'b00, 1'b0);
        checks++; if (lat !== 3) begin failures++; $display("FAIL sb_lat got=%0d exp=3", lat); end
        checks++; if (we_cnt !== 1) begin failures++; $display("FAIL sb_we_cnt got=%0d exp=1", we_cnt); end
        checks++; if (wr_data !== 32'h1122_AA44) begin failures++; $display("FAIL sb_wdata got=%h exp=1122aa44", wr_data); end
        checks++; if (mem[8] !== 32'h1122_AA44) begin failures++; $display("FAIL sb_ram got=%h exp=1122aa44", mem[8]); end
        checks++; if (rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sb_rdata_hold got=%h exp=deadbeef", rdata_o); end
        mem[13] = 32'hAABB_CCDD;
        do_access(1'b1, 32'h36, 32'h1234_BEEF, 2'b01, 1'b0);
        checks++; if (lat !== 3) begin failures++; $display("FAIL sh_lat got=%0d exp=3", lat); end
        checks++; if (mem[13] !== 32'hBEEF_CCDD) begin failures++; $display("FAIL sh_ram got=%h exp=beefccdd", mem[13]); end
        mem[14] = 32'h0102_0304;
        do_access(1'b1, 32'h3B, 32'h0000_00E7, 2'b00, 1'b0);
        checks++; if (mem[14] !== 32'hE702_0304) begin failures++; $display("FAIL sb3_ram got=%h exp=e7020304", mem[14]); end
    endtask

    task automatic test_load_ext();
        mem[12] = 32'h8000_FF80;
        do_access(1'b0, 32'h30, 32'h0, 2'b00, 1'b0);
        checks++; if (res_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb got=%h exp=ffffff80", res_rdata); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL lb_lat got=%0d exp=2", lat); end
        do_access(1'b0, 32'h30, 32'h0, 2'b00, 1'b1);
        checks++; if (res_rdata !== 32'h0000_0080) begin failures++; $display("FAIL lbu got=%h exp=00000080", res_rdata); end
        do_access(1'b0, 32'h32, 32'h0, 2'b01, 1'b0);
        checks++; if (res_rdata !== 32'hFFFF_8000) begin failures++; $display("FAIL lh got=%h exp=ffff8000", res_rdata); end
        do_access(1'b0, 32'h32, 32'h0, 2'b01, 1'b1);
        checks++; if (res_rdata !== 32'h0000_8000) begin failures++; $display("FAIL lhu got=%h exp=00008000", res_rdata); end
        do_access(1'b0, 32'h31, 32'h0, 2'b00, 1'b0);
        checks++; if (res_rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL lb1 got=%h exp=ffffffff", res_rdata); end
        do_access(1'b0, 32'h30, 32'h0, 2'b01, 1'b0);
        checks++; if (res_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lh0 got=%h exp=ffffff80", res_rdata); end
    endtask

    task automatic test_errors();
        mem[16] = 32'h0BAD_F00D;
        do_access(1'b0, 32'h33, 32'h0, 2'b01, 1'b0);
        checks++; if (lat !== 1) begin failures++; $display("FAIL lh_mis_lat got=%0d exp=1", lat); end
        checks++; if (res_err !== 1'b1) begin failures++; $display("FAIL lh_mis_err got=%b exp=1", res_err); end
        checks++; if (res_rdata !== 32'h0) begin failures++; $display("FAIL lh_mis_rdata got=%h exp=0", res_rdata); end
        do_access(1'b1, 32'h42, 32'h5555_5555, 2'b10, 1'b0);
        checks++; if (lat !== 1) begin failures++; $display("FAIL sw_mis_lat got=%0d exp=1", lat); end
        checks++; if (res_err !== 1'b1) begin failures++; $display("FAIL sw_mis_err got=%b exp=1", res_err); end
        checks++; if (we_cnt !== 0) begin failures++; $display("FAIL sw_mis_we got=%0d exp=0", we_cnt); end
        checks++; if (mem[16] !== 32'h0BAD_F00D) begin failures++; $display("FAIL sw_mis_ram got=%h exp=0badf00d", mem[16]); end
        do_access(1'b1, 32'h40, 32'h6666_6666, 2'b11, 1'b0);
        checks++; if ({res_err, we_cnt[0], lat[1:0]} !== 4'b1001) begin failures++; $display("FAIL size11 got err=%b we=%0d lat=%0d exp err=1 we=0 lat=1", res_err, we_cnt, lat); end
        checks++; if (mem[16] !== 32'h0BAD_F00D) begin failures++; $display("FAIL size11_ram got=%h exp=0badf00d", mem[16]); end
        @(negedge clk);
        checks++; if ({busy_o, done_o, err_o} !== 3'b000) begin failures++; $display("FAIL err_release got=%b exp=000", {busy_o, done_o, err_o}); end
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        saw_done = 1'b0;
        mem[20] = 32'h5566_7788;
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h50; wdata_i = 32'h99; size_i = 2'b00; unsigned_i = 1'b0;
        @(posedge clk);
        #1 req_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rmw_busy got=%b exp=1", busy_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy_o, mem_we_o} !== 2'b00) begin failures++; $display("FAIL abort_drop got=%b exp=00", {busy_o, mem_we_o}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_o || mem_we_o) saw_done = 1'b1;
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_o || mem_we_o) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", saw_done); end
        checks++; if (mem[20] !== 32'h5566_7788) begin failures++; $display("FAIL abort_ram got=%h exp=55667788", mem[20]); end
        do_access(1'b0, 32'h50, 32'h0, 2'b10, 1'b0);
        checks++; if (res_rdata !== 32'h5566_7788) begin failures++; $display("FAIL post_reset_lw got=%h exp=55667788", res_rdata); end
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 32'h60, 32'hA5A5_0F0F, 2'b10, 1'b0);
        @(negedge clk);
        checks++; if ({busy_o, done_o} !== 2'b00) begin failures++; $display("FAIL b2b_idle got=%b exp=00", {busy_o, done_o}); end
        do_access(1'b0, 32'h61, 32'h0, 2'b00, 1'b1);
        checks++; if (res_rdata !== 32'h0000_000F) begin failures++; $display("FAIL b2b_lbu got=%h exp=0000000f", res_rdata); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_lat got=%0d exp=2", lat); end
    endtask

    task automatic test_bounds();
        mem[0] = 32'h1357_9BDF;
        do_access(1'b1, 32'h400, 32'hCAFE_F00D, 2'b10, 1'b0);
`ifdef RAM_BOUNDS_CHECK_EN
        checks++; if (res_err !== 1'b1) begin failures++; $display("FAIL oob_err got=%b exp=1", res_err); end
        checks++; if (we_cnt !== 0) begin failures++; $display("FAIL oob_we got=%0d exp=0", we_cnt); end
        checks++; if (mem[0] !== 32'h1357_9BDF) begin failures++; $display("FAIL oob_ram got=%h exp=13579bdf", mem[0]); end
`else
        checks++; if (res_err !== 1'b0) begin failures++; $display("FAIL wrap_err got=%b exp=0", res_err); end
        checks++; if (we_cnt !== 1) begin failures++; $display("FAIL wrap_we got=%0d exp=1", we_cnt); end
        checks++; if (wr_addr !== 32'h400) begin failures++; $display("FAIL wrap_waddr got=%h exp=00000400", wr_addr); end
        checks++; if (mem[0] !== 32'hCAFE_F00D) begin failures++; $display("FAIL wrap_ram got=%h exp=cafef00d", mem[0]); end
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_word();
        test_subword_store();
        test_load_ext();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_bounds();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_lsu_adapter.md
Name: ram_lsu_adapter

Overview:
- Sits between the core's memory-access stage and the word-only data RAM (word write port plus combinational word read port).
- Converts byte, halfword and word loads/stores into RAM word accesses.
- Sub-word stores are done as read-modify-write.
- Core side uses a req/busy/done handshake; it also flags misaligned accesses.

Parameters:
- DEPTH, 256, number of 32-bit RAM words; used by the optional bounds check.
- AW, 8, word-index width, equal to clog2(DEPTH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  1  core access request; sampled only while busy_o=0
- we_i  in  1  1=store, 0=load
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-aligned
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
- busy_o  out  1  adapter not idle
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o: misaligned, illegal size, or out of bounds
- rdata_o  out  32  load result, valid with done_o
- mem_we_o  out  1  RAM write enable
- mem_waddr_o  out  32  RAM write byte address, word-aligned
- mem_wdata_o  out  32  RAM write data
- mem_raddr_o  out  32  RAM read byte address, word-aligned
- mem_rdata_i  in  32  RAM combinational read data

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: state IDLE; busy_o, done_o, err_o, mem_we_o = 0; rdata_o, mem_* addresses and wdata = 0.
- States: IDLE, RD, WR, DONE.
- Accept: in IDLE with req_i=1, latch we_i, addr_i, wdata_i, size_i, unsigned_i, and an error flag.
  - Error flag = (size_i==11) | (size_i==01 & addr_i[0]) | (size_i==10 & addr_i[1:0]!=0).
  - Requests arriving while busy_o=1 are ignored; the core must hold req_i until busy_o rises, then drop it.
- Transitions:
  - error: IDLE -> DONE.
  - load: IDLE -> RD -> DONE.
  - word store: IDLE -> WR -> DONE.
  - byte/half store: IDLE -> RD -> WR -> DONE.
  - DONE -> IDLE always.
- busy_o = (state != IDLE). done_o = (state == DONE). err_o is registered and held through DONE.
- RD:
  - mem_raddr_o = {addr[31:2],2'b00}.
  - mem_rdata_i is captured into a word register at the clock edge.
  - Load: extract the lane selected by addr[1:0] (byte) or addr[1] (half), extend per unsigned_i, register into rdata_o.
- WR:
  - mem_we_o = 1 for exactly this cycle; mem_waddr_o = word-aligned address.
  - Word store: mem_wdata_o = wdata.
  - Sub-word store: mem_wdata_o = captured old word with the target lane replaced by wdata[7:0] or wdata[15:0]; other lanes unchanged.
- Latency from accept edge to done_o:
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
  - error: 1 cycle.
- On error: no RAM access (mem_we_o stays 0); rdata_o = 0.
- mem_we_o is combinational from state only, and is 0 outside WR.
- Reset mid-operation: state returns to IDLE asynchronously and mem_we_o drops immediately. An RMW interrupted in RD leaves the RAM unchanged. No done_o is produced for the aborted request.
- rdata_o holds its value until the next load completes; store completion does not alter it.
- Back-to-back: a new request can be accepted in the IDLE cycle after DONE (minimum 1 idle cycle between accesses).

Optional Feature:
- Macro RAM_BOUNDS_CHECK_EN.
- Defined: an address with addr[31:2] >= DEPTH is an error at accept, taking the same path as misaligned (IDLE -> DONE, err_o=1, no RAM access).
- Undefined: no bounds check; the RAM word index wraps per its own decoding.

Decomposition:
- Shared defines file holds: size encodings (SizeByte/SizeHalf/SizeWord), state encodings, and the existing WriteEnable/ZeroWord constants.
- One natural sub-module, lsu_byte_lane. It is purely combinational and provides two functions:
  - lane extract plus sign/zero extension;
  - lane merge for stores.
- The FSM and registers stay in ram_lsu_adapter.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> one WR cycle with mem_wdata_o=0xDEADBEEF; load done_o 2 cycles after accept, rdata_o=0xDEADBEEF, err_o=0.
- RAM word @0x20 = 0x11223344; byte store 0xAA @0x21 -> RD then WR; written word 0x1122AA44; other lanes intact.
- Word 0x8000FF80 @0x30: lb @0x30 -> 0xFFFFFF80; lbu @0x30 -> 0x00000080; lh @0x32 -> 0xFFFF8000; lhu @0x32 -> 0x00008000.
- Misaligned lh @0x33, sw @0x42, size=11 -> done_o 1 cycle after accept, err_o=1, mem_we_o never asserted, RAM unchanged.
- Assert rst_n=0 during the RD cycle of sb @0x50 -> busy_o and mem_we_o drop immediately; RAM word @0x50 unchanged; no done_o; next request is accepted normally after reset release.
- With RAM_BOUNDS_CHECK_EN and DEPTH=256: sw @0x400 -> err_o=1, no write; without the macro -> write issued, mem_waddr_o=0x400.
